// File: rtl/regfile_wb_sched.sv
// Round-robin write-port scheduler for a 4 x 8-bit register file (ports A and B).
// Optional pending-write scoreboard with RAW hazard flag: define REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_sched #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid,
    input  logic [ADDR_W-1:0]           a_wb,
    input  logic signed [DATA_W-1:0]    a_data,
    output logic                        a_ready,
    input  logic                        b_valid,
    input  logic [ADDR_W-1:0]           b_wb,
    input  logic signed [DATA_W-1:0]    b_data,
    output logic                        b_ready,
    output logic                        reg_en,
    output logic [ADDR_W-1:0]           wb,
    output logic signed [DATA_W-1:0]    data,
    input  logic                        issue_valid,
    input  logic [ADDR_W-1:0]           issue_wb,
    input  logic [ADDR_W-1:0]           ra,
    input  logic [ADDR_W-1:0]           rb,
    output logic [(1<<ADDR_W)-1:0]      busy,
    output logic                        hazard
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

    pri_t                     pri, pri_nxt;
    logic                     xfer;
    logic [ADDR_W-1:0]        xfer_wb;
    logic signed [DATA_W-1:0] xfer_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pri <= PRI_A;
        else      pri <= pri_nxt;
    end

    // Grants are gated by reset so nothing handshakes while the block is held.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        pri_nxt = pri;
        if (rst) begin
            case (pri)
                PRI_A: begin
                    a_ready = a_valid;
                    b_ready = b_valid & ~a_valid;
                end
                PRI_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid & ~b_valid;
                end
                default: ;
            endcase
            if (a_ready)      pri_nxt = PRI_B;
            else if (b_ready) pri_nxt = PRI_A;
        end
    end

    assign xfer      = a_ready | b_ready;
    assign xfer_wb   = a_ready ? a_wb   : b_wb;
    assign xfer_data = a_ready ? a_data : b_data;

    // Address/data hold their last value when idle; only reg_en drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_en <= 1'b0;
            wb     <= '0;
            data   <= '0;
        end else begin
            reg_en <= xfer;
            if (xfer) begin
                wb   <= xfer_wb;
                data <= xfer_data;
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NREG-1:0] set_vec, clr_vec;

    assign set_vec = issue_valid ? (NREG'(1) << issue_wb) : '0;
    assign clr_vec = xfer        ? (NREG'(1) << xfer_wb)  : '0;

    // Set is OR-ed in after the clear so a newly issued producer wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= (busy & ~clr_vec) | set_vec;
    end

    assign hazard = busy[ra] | busy[rb];
`else
    logic unused_sb;

    assign unused_sb = ^{issue_valid, issue_wb, ra, rb};
    assign busy      = '0;
    assign hazard    = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler for the 4 x 8-bit register file. Two producers (port A: ALU writeback; port B: load/immediate path) compete for the register file's single write port (`reg_en`/`wb`/`data`). The block arbitrates round-robin with a valid/ready handshake and drives the write port from registered outputs. An optional scoreboard tracks registers with outstanding writes and flags read-after-write hazards on the two read addresses.

## Interface
- `DATA_W`, default 8: data width; matches the register file.
- `ADDR_W`, default 2: register address width (4 registers).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `a_valid` in 1: port A write request.
- `a_wb` in ADDR_W: port A destination register.
- `a_data` in DATA_W (signed): port A write data.
- `a_ready` out 1: port A granted this cycle.
- `b_valid`, `b_wb`, `b_data`, `b_ready`: same as port A, for port B.
- `reg_en` out 1: register file write enable.
- `wb` out ADDR_W: register file write address.
- `data` out DATA_W (signed): register file write data.
- `issue_valid` in 1: an instruction has issued that will later write `issue_wb`.
- `issue_wb` in ADDR_W: destination of the issued instruction.
- `ra`, `rb` in ADDR_W: current read addresses of the register file.
- `busy` out 4: per-register pending-write flags.
- `hazard` out 1: `busy[ra] | busy[rb]`, combinational.

## Operation
- Handshake: a transfer occurs on a posedge where `x_valid && x_ready`.
  - A requester holds `valid`, `wb` and `data` stable until it sees `ready`.
  - `ready` is combinational from `valid`, the priority pointer and reset.
  - At most one of `a_ready`/`b_ready` is high in any cycle.
- Arbitration uses a 1-bit priority pointer `pri` (0 = A preferred), with two states: PRI_A and PRI_B.
  - Only one port valid: that port is granted, regardless of `pri`.
  - Both ports valid: the preferred port is granted.
  - After any transfer, `pri` points to the other port. PRI_A -> PRI_B on an A transfer; PRI_B -> PRI_A on a B transfer.
  - No transfer: `pri` holds.
- Write port: on a transfer, `reg_en`<=1 and `wb`/`data` <= the granted port's `wb`/`data`. With no transfer, `reg_en`<=0 and `wb`/`data` hold their last values.
  - The register file samples on negedge, so a write lands in the same cycle `reg_en` is high: 1 posedge + half a cycle after the handshake.
- Back-to-back: one transfer per cycle is sustained. A continuously valid port alternates with the other port when both are valid.
- Data passes through unmodified (no width conversion, sign preserved).
- Scoreboard (when enabled):
  - `issue_valid` sets `busy[issue_wb]` at the posedge.
  - A transfer to register `r` clears `busy[r]` at the same posedge.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is outstanding).
  - Set and clear of different registers both take effect.
  - A transfer to a non-busy register is legal and leaves that bit 0.

## Timing
- Reset is asserted asynchronously, takes effect immediately, and is released synchronously by downstream design.
- While `rst`=0:
  - `reg_en`=0, `wb`=0, `data`=0, `busy`=4'b0000, `pri`=PRI_A.
  - `a_ready`=`b_ready`=0; `hazard`=0.
- Reset mid-transfer: any pending request is dropped and no write is issued. Requesters re-present their request after reset.
- Latency from handshake posedge to `reg_en` high: 1 cycle. Handshake to register file update: 1.5 cycles.
- `ready` and `hazard` are combinational; all other outputs are registered.

## Configuration
- `REGFILE_WB_SCOREBOARD_EN` defined: the `busy` register and `hazard` logic are built as described.
- Not defined:
  - `busy` is tied to 4'b0000 and `hazard` to 0.
  - `issue_valid`, `issue_wb`, `ra`, `rb` are ignored.
  - No scoreboard flops are instantiated.
- Arbitration and the write path are identical in both builds.

## Test plan
- Reset:
  - Drive `rst`=0 asynchronously mid-cycle while `a_valid`=1 -> all outputs 0 immediately, `a_ready`=0.
  - Release reset, then A requests -> A is granted on the first cycle.
- Single requester: A presents `a_wb`=2, `a_data`=-5 for one cycle -> `a_ready`=1. Next cycle `reg_en`=1, `wb`=2, `data`=8'hFB, and register 2 reads -5 after the negedge.
- Contention: A and B held valid for 4 cycles from reset -> grant order A,B,A,B. `reg_en` stays high for 4 consecutive cycles with the matching `wb`/`data`.
- Hold: B valid alone for 3 cycles -> B granted every cycle, and `pri` ends at PRI_A. Then A and B both valid -> A is granted.
- Scoreboard (macro defined):
  - `issue_valid` with `issue_wb`=1, then `ra`=1 -> `busy`=4'b0010, `hazard`=1.
  - A writes reg 1 -> `busy`=0, `hazard`=0.
  - Same-cycle issue and write to reg 3 -> `busy[3]`=1.
- Macro undefined: the same issue/read sequence -> `busy`=0 and `hazard`=0 throughout, and the write path matches the defined build cycle for cycle.
